// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches one block from 16-bit main memory word by word, fills the data array, then writes the tag.
// Optional critical-word-first ordering is enabled by defining CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [OFF_W-1:0]  data_word_sel,
  output logic [15:0]       fill_data,
  output logic              write_tag_array
);

  typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

  localparam logic [3:0] WORDS_C = 4'(WORDS);

  state_t            state_q, state_d;
  logic [3:0]        issue_cnt_q, issue_cnt_d;
  logic [3:0]        recv_cnt_q, recv_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  start_off;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]  start_off_q, start_off_d;
  assign start_off = start_off_q;
`else
  assign start_off = '0;
`endif

  // The byte-lane bit (and the word offset without critical-word-first) never reach the datapath.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_address[OFF_W:0];

  logic             issue_live;
  logic             wr_word;
  logic [OFF_W-1:0] issue_off;
  logic [OFF_W-1:0] req_off;

  assign issue_live = (issue_cnt_q < WORDS_C);
  // Once every request is out, keep presenting the final request's address.
  assign issue_off  = issue_live ? issue_cnt_q[OFF_W-1:0] : OFF_W'(WORDS - 1);
  assign req_off    = issue_off + start_off;
  assign wr_word    = (state_q == FILL) && memory_data_valid && (recv_cnt_q < WORDS_C);

  assign fsm_busy         = (state_q != IDLE);
  assign mem_read         = (state_q == FILL) && issue_live;
  assign memory_address   = base_q + ADDR_W'({req_off, 1'b0});
  assign write_data_array = wr_word;
  assign data_word_sel    = recv_cnt_q[OFF_W-1:0] + start_off;
  assign fill_data        = memory_data;
  assign write_tag_array  = (state_q == TAG);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    base_d      = base_q;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    start_off_d = start_off_q;
`endif
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d      = {miss_address[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
          start_off_d = miss_address[OFF_W:1];
`endif
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (issue_live) issue_cnt_d = issue_cnt_q + 4'd1;
        if (wr_word) begin
          recv_cnt_d = recv_cnt_q + 4'd1;
          if (recv_cnt_q == WORDS_C - 4'd1) state_d = TAG;
        end
      end
      TAG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_q      <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      start_off_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      start_off_q <= start_off_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: randomized memory latency and data against a block-level fill model.
module tb_cache_fill_fsm;
  localparam int WORDS  = 8;
  localparam int ADDR_W = 16;
  localparam int OFF_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              miss_detected = 1'b0;
  logic [ADDR_W-1:0] miss_address = '0;
  logic              memory_data_valid = 1'b0;
  logic [15:0]       memory_data = '0;
  logic              fsm_busy, mem_read, write_data_array, write_tag_array;
  logic [ADDR_W-1:0] memory_address;
  logic [OFF_W-1:0]  data_word_sel;
  logic [15:0]       fill_data;

  int checks = 0;
  int failures = 0;

  cache_fill_fsm #(.WORDS(WORDS), .ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .mem_read(mem_read), .memory_address(memory_address),
    .write_data_array(write_data_array), .data_word_sel(data_word_sel),
    .fill_data(fill_data), .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  function automatic int start_word(input logic [15:0] a);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    return (int'(a) % (2 * WORDS)) / 2;
`else
    return 0;
`endif
  endfunction

  // Address of the i-th request of the block containing byte address a.
  function automatic logic [15:0] exp_req(input logic [15:0] a, input int i);
    int base;
    base = (int'(a) / (2 * WORDS)) * (2 * WORDS);
    return 16'((base + 2 * ((start_word(a) + i) % WORDS)) % 65536);
  endfunction

  function automatic logic [OFF_W-1:0] exp_sel(input logic [15:0] a, input int j);
    return OFF_W'((start_word(a) + j) % WORDS);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (fsm_busy !== 1'b0 || mem_read !== 1'b0 || write_tag_array !== 1'b0 || write_data_array !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: busy=%b rd=%b wr=%b tag=%b required all 0",
                 c, fsm_busy, mem_read, write_data_array, write_tag_array);
      end
      @(negedge clk);
    end
  endtask

  // One complete miss. fixed_lat<0 picks a random latency per word; exp_idle<0 uses the model's
  // idle cycle; abort_at>=0 applies reset after that many words have been written.
  task automatic test_fill(input logic [15:0] addr, input int fixed_lat, input int exp_idle,
                           input bit inject, input int abort_at);
    int ret[WORDS];
    int rcv, tag_c, fall, lat, want_idle;
    bit v, real_ret;
    logic [15:0] d;
    for (int i = 0; i < WORDS; i++) begin
      lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
      ret[i] = i + 1 + lat;
      if (i > 0 && ret[i] <= ret[i-1]) ret[i] = ret[i-1] + 1;
    end
    tag_c = ret[WORDS-1] + 1;
    want_idle = (exp_idle >= 0) ? exp_idle : tag_c + 1;

    @(negedge clk);
    miss_detected = 1'b1;
    miss_address = addr;
    memory_data_valid = 1'($urandom_range(0, 1));
    memory_data = 16'($urandom);
    #1;
    checks++;
    if (fsm_busy !== 1'b0 || write_data_array !== 1'b0) begin
      failures++;
      $display("FAIL idle_at_miss %h: busy=%b wr=%b required 0 0", addr, fsm_busy, write_data_array);
    end
    @(posedge clk);

    rcv = 0;
    fall = -1;
    for (int t = 1; t <= 100 && fall < 0; t++) begin
      @(negedge clk);
      miss_detected = (inject && t <= tag_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      miss_address = inject ? 16'h4000 : 16'($urandom);
      real_ret = (rcv < WORDS) && (t == ret[rcv]);
      v = real_ret;
      if (t == tag_c) v = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      memory_data_valid = v;
      memory_data = d;
      #1;
      if (fsm_busy === 1'b0) fall = t;

      checks++;
      if (fsm_busy !== (t <= tag_c)) begin
        failures++;
        $display("FAIL busy %h t=%0d: got %b required %b", addr, t, fsm_busy, (t <= tag_c));
      end
      checks++;
      if (mem_read !== (t <= WORDS)) begin
        failures++;
        $display("FAIL mem_read %h t=%0d: got %b required %b", addr, t, mem_read, (t <= WORDS));
      end
      checks++;
      if (memory_address !== exp_req(addr, (t <= WORDS) ? t - 1 : WORDS - 1)) begin
        failures++;
        $display("FAIL mem_addr %h t=%0d: got %h required %h", addr, t, memory_address,
                 exp_req(addr, (t <= WORDS) ? t - 1 : WORDS - 1));
      end
      checks++;
      if (write_data_array !== real_ret) begin
        failures++;
        $display("FAIL wr_data %h t=%0d: got %b required %b", addr, t, write_data_array, real_ret);
      end
      if (real_ret) begin
        checks++;
        if (data_word_sel !== exp_sel(addr, rcv) || fill_data !== d) begin
          failures++;
          $display("FAIL word %0d of %h: sel=%0d data=%h required sel=%0d data=%h",
                   rcv, addr, data_word_sel, fill_data, exp_sel(addr, rcv), d);
        end
        rcv++;
      end
      checks++;
      if (write_tag_array !== (t == tag_c)) begin
        failures++;
        $display("FAIL tag %h t=%0d: got %b required %b", addr, t, write_tag_array, (t == tag_c));
      end

      if (abort_at >= 0 && real_ret && rcv == abort_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        miss_detected = 1'b0;
        memory_data_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        memory_data_valid = 1'b1;
        memory_data = 16'h0000;
        #1;
        checks++;
        if (fsm_busy !== 1'b0 || mem_read !== 1'b0 || write_data_array !== 1'b0 ||
            write_tag_array !== 1'b0 || data_word_sel !== '0 || memory_address !== '0 ||
            fill_data !== 16'h0000) begin
          failures++;
          $display("FAIL reset_midfill: busy=%b rd=%b wr=%b tag=%b sel=%0d addr=%h data=%h required all 0",
                   fsm_busy, mem_read, write_data_array, write_tag_array, data_word_sel,
                   memory_address, fill_data);
        end
        memory_data_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end

    checks++;
    if (fall != want_idle) begin
      failures++;
      $display("FAIL idle_time %h: busy fell at cycle %0d required %0d", addr, fall, want_idle);
    end
  endtask

  task automatic test_random_fills();
    for (int n = 0; n < 8; n++)
      test_fill(16'($urandom), -1, -1, 1'($urandom_range(0, 1)), -1);
  endtask

  initial begin
    test_reset();
    test_fill(16'h1236, 4, 14, 1'b0, -1);
    test_fill(16'h1236, 0, 10, 1'b0, -1);
    test_fill(16'h1230, 2, -1, 1'b1, -1);
    test_fill(16'h1230, 3, -1, 1'b0, 3);
    test_fill(16'h0010, -1, -1, 1'b0, -1);
    test_fill(16'hFFFA, 1, 11, 1'b0, -1);
    test_random_fills();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
